// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of {instr, pc} pairs with flush and a combinational head read.
// Optional IF_ID_FLUSH_COUNT_EN adds a saturating count of flushes that discarded entries.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_instr,
  input  logic [W-1:0]               in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_instr,
  output logic [W-1:0]               out_pc,
  input  logic                       flush,
`ifdef IF_ID_FLUSH_COUNT_EN
  output logic [15:0]                flush_count,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  instr_mem [DEPTH];
  logic [W-1:0]  pc_mem    [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          pop;

  // in_ready depends only on stored state, so out_ready never reaches it.
  assign in_ready  = (count_reg < CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign occupancy = count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= in_instr;
      pc_mem[wr_ptr_reg]    <= in_pc;
    end
  end

  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : '0;

`ifdef IF_ID_FLUSH_COUNT_EN
  logic [15:0] flush_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_count_reg <= '0;
    end else if (flush && (count_reg != '0) && (flush_count_reg != 16'hFFFF)) begin
      flush_count_reg <= flush_count_reg + 16'd1;
    end
  end

  assign flush_count = flush_count_reg;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized + directed scoreboard bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam int W     = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_instr = '0;
  logic [W-1:0]  in_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_instr;
  logic [W-1:0]  out_pc;
  logic          flush = 1'b0;
  logic [CW-1:0] occupancy;
`ifdef IF_ID_FLUSH_COUNT_EN
  logic [15:0]   flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] instr;
    logic [W-1:0] pc;
  } entry_t;

  entry_t exp_q[$];
  int     exp_flushes = 0;

  if_id_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .flush(flush),
`ifdef IF_ID_FLUSH_COUNT_EN
    .flush_count(flush_count),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a plain FIFO of accepted entries, updated on each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      if (flush) begin
        if (exp_q.size() != 0 && exp_flushes < 65535) exp_flushes++;
        exp_q.delete();
      end else begin
        bit do_pop;
        bit do_push;
        do_pop  = (exp_q.size() != 0) && out_ready;
        do_push = in_valid && (exp_q.size() < DEPTH);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back('{instr: in_instr, pc: in_pc});
      end
    end
  end

  always @(negedge rst) begin
    exp_q.delete();
    exp_flushes = 0;
  end

  // Monitor: compares every visible DUT output against the model mid-cycle.
  always @(negedge clk) begin
    check("occupancy", 64'(occupancy), 64'(exp_q.size()));
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("head_instr", 64'(out_instr), 64'(exp_q[0].instr));
      check("head_pc", 64'(out_pc), 64'(exp_q[0].pc));
    end else begin
      check("idle_instr", 64'(out_instr), 64'h0);
      check("idle_pc", 64'(out_pc), 64'h0);
    end
    $display("cyc t=%0t iv=%0b ir=%0b ov=%0b or=%0b fl=%0b occ=%0d pc=%0h",
             $time, in_valid, in_ready, out_valid, out_ready, flush, occupancy, out_pc);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [W-1:0] instr, input logic [W-1:0] pc,
                       input bit ordy, input bit fl);
    in_valid  = iv;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    cyc();
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state, then release between edges.
    #2;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // Single push into an empty queue with decode stalled.
    drive(1'b1, 32'h8C010004, 32'h00040000, 1'b0, 1'b0);
    check("single_valid", 64'(out_valid), 64'h1);
    check("single_instr", 64'(out_instr), 64'h8C010004);
    check("single_pc", 64'(out_pc), 64'h00040000);
    check("single_occ", 64'(occupancy), 64'h1);

    // Fill, ignored third push, then drain in order.
    drive(1'b1, 32'h11110004, 32'h00040004, 1'b0, 1'b0);
    check("fill_occ", 64'(occupancy), 64'h2);
    check("fill_in_ready", 64'(in_ready), 64'h0);
    drive(1'b1, 32'h22220008, 32'h00040008, 1'b0, 1'b0);
    check("full_ignore_pc", 64'(out_pc), 64'h00040000);
    check("full_ignore_occ", 64'(occupancy), 64'h2);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain1_pc", 64'(out_pc), 64'h00040004);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain2_valid", 64'(out_valid), 64'h0);

    // Full with push and pop requested: only the pop happens.
    drive(1'b1, 32'hA0, 32'h00050000, 1'b0, 1'b0);
    drive(1'b1, 32'hA4, 32'h00050004, 1'b0, 1'b0);
    drive(1'b1, 32'hA8, 32'h00050008, 1'b1, 1'b0);
    check("full_pushpop_occ", 64'(occupancy), 64'h1);
    check("full_pushpop_pc", 64'(out_pc), 64'h00050004);

    // Flush with two entries and a simultaneous push.
    drive(1'b1, 32'hB0, 32'h00060000, 1'b0, 1'b0);
    check("preflush_occ", 64'(occupancy), 64'h2);
    drive(1'b1, 32'hB4, 32'h00060004, 1'b0, 1'b1);
    check("flush_occ", 64'(occupancy), 64'h0);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_in_ready", 64'(in_ready), 64'h1);
`ifdef IF_ID_FLUSH_COUNT_EN
    check("flush_count", 64'(flush_count), 64'h1);
`endif
    // Flush on an empty queue must not count.
    drive(1'b0, '0, '0, 1'b0, 1'b1);
`ifdef IF_ID_FLUSH_COUNT_EN
    check("flush_empty_count", 64'(flush_count), 64'h1);
`endif

    // Streaming across pointer wrap.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'hC000 + 32'(k), 32'h00040000 + 32'(4 * k), 1'b1, 1'b0);
      check("stream_occ", 64'(occupancy), 64'h1);
      check("stream_pc", 64'(out_pc), 64'(32'h00040000 + 32'(4 * k)));
    end
    idle();

    // Asynchronous reset mid-cycle with two entries stored.
    drive(1'b1, 32'hD0, 32'h00070000, 1'b0, 1'b0);
    drive(1'b1, 32'hD4, 32'h00070004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'h0);
    check("async_rst_occ", 64'(occupancy), 64'h0);
    check("async_rst_in_ready", 64'(in_ready), 64'h1);
    check("async_rst_instr", 64'(out_instr), 64'h0);
`ifdef IF_ID_FLUSH_COUNT_EN
    check("async_rst_fcount", 64'(flush_count), 64'h0);
`endif
    cyc();
    rst = 1'b1;
    drive(1'b1, 32'hE0, 32'h00080000, 1'b0, 1'b0);
    check("post_rst_push", 64'(out_pc), 64'h00080000);

    // Randomized traffic; the monitor checks every cycle.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
`ifdef IF_ID_FLUSH_COUNT_EN
    check("rand_flush_count", 64'(flush_count), 64'(exp_flushes));
`endif
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
